uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit half of the UART: a parameterised transmit FIFO feeding a serialiser that drives the TX line with start, data, optional parity and stop bits at a fixed clocks-per-bit rate. Host logic pushes bytes with a one-cycle strobe. The block drains them back-to-back onto `Tx` and reports buffer status with the same flag set as the receive FIFO (`FIFO_Empty`, `FIFO_Full`, `FIFO_Overflow`), so the two ends are symmetric.

## Interface
- `DATA_BITS`, 8: data bits per frame and width of each FIFO entry.
- `FIFO_WIDTH`, 2: log2 of FIFO depth (ENTRIES = 2**FIFO_WIDTH).
- `CLKS_PER_BIT`, 16: `clk` cycles per serial bit; must be ≥ 2.
- `PARITY_EN`, 1: 1 = parity bit inserted after the data bits.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity; ignored when `PARITY_EN` = 0.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `Tx_Data`  in  DATA_BITS  byte to enqueue.
- `Load_Data`  in  1  one-cycle push strobe; `Tx_Data` is sampled on the same edge.
- `BIST_Mode`  in  1  1 = no new frame may start; pushes are still accepted.
- `Tx`  out  1  serial line; idle level is 1.
- `Tx_Busy`  out  1  high while a frame is on the line.
- `Tx_Done`  out  1  one-cycle pulse when a stop bit completes.
- `FIFO_Empty`  out  1  high when count = 0.
- `FIFO_Full`  out  1  high when count = ENTRIES.
- `FIFO_Overflow`  out  1  sticky flag: a push was dropped.

## Operation
- Reset (`rst` = 0 at an edge) forces all outputs to their reset values after that edge:
  - `Tx` = 1, `Tx_Busy` = 0, `Tx_Done` = 0
  - `FIFO_Empty` = 1, `FIFO_Full` = 0, `FIFO_Overflow` = 0
  - pointers, count, bit counter and baud counter = 0; FSM = IDLE.
- Reset mid-frame aborts the frame and discards all queued data. Every output is a register.
- FIFO:
  - Circular buffer; read and write pointers are FIFO_WIDTH bits wide and wrap naturally.
  - Count is FIFO_WIDTH+1 bits wide.
- Push (`Load_Data` = 1):
  - Count < ENTRIES: entry is written and count increments.
  - Count = ENTRIES with no pop on the same edge: data is dropped and `FIFO_Overflow` is set.
  - Push and pop on the same edge: both take effect and count is unchanged. This includes the full case, where the push is accepted.
- `FIFO_Overflow` clears on reset or on the next pop.
- FSM states are IDLE, START, DATA, PARITY, STOP.
  - IDLE → START: FIFO non-empty and `BIST_Mode` = 0. On that edge, pop the head into the shift register, set `Tx` = 0 and `Tx_Busy` = 1, and compute parity from the popped byte.
  - START → DATA after CLKS_PER_BIT cycles. DATA sends the LSB first, one bit per CLKS_PER_BIT cycles, for DATA_BITS bits.
  - DATA → PARITY if `PARITY_EN` = 1, otherwise DATA → STOP. PARITY drives the parity bit for CLKS_PER_BIT cycles.
    - Even: XOR of the data bits.
    - Odd: inverted XOR of the data bits.
  - STOP drives `Tx` = 1 for CLKS_PER_BIT cycles. At the end, `Tx_Done` pulses for one cycle, then:
    - FIFO non-empty and `BIST_Mode` = 0: go to START, popping on the same edge. There is no idle gap.
    - Otherwise: go to IDLE and drop `Tx_Busy`.
- `BIST_Mode` rising mid-frame does not abort the frame. The frame completes and the FSM then holds in IDLE.
- The baud counter counts from 0 to CLKS_PER_BIT−1 and reloads to 0 at every bit boundary.

## Timing
- Push-to-line latency from idle-empty:
  - Push at edge N: `FIFO_Empty` = 0 after edge N.
  - Pop and `Tx` = 0 after edge N+1; `FIFO_Empty` returns to 1 after edge N+1.
- Frame length is F = (2 + DATA_BITS + PARITY_EN) × CLKS_PER_BIT cycles.
  - `Tx` changes only on bit boundaries.
  - `Tx_Done` is high in the cycle after the last STOP cycle, coincident with the next start bit in back-to-back operation.
- Status flags update on the same edge as the push or pop that changes count.

## Test plan
- Single frame, CLKS_PER_BIT = 4, even parity. Push 0xA5 into an idle block.
  - `Tx` = 0 for 4 cycles starting one cycle after the push.
  - Data bits 1,0,1,0,0,1,0,1 for 4 cycles each, then parity 0, then stop 1.
  - `Tx_Done` pulses 44 cycles after the start bit begins.
- Odd parity with 0x07: parity bit = 0. Same stimulus with even parity: parity bit = 1.
- Back-to-back: push 0x11, 0x22, 0x33 on consecutive cycles.
  - Three contiguous 44-cycle frames with no idle cycles between them.
  - `Tx_Busy` stays high for 132 cycles; `FIFO_Empty` = 1 after the third pop.
- Overflow, with `BIST_Mode` = 1 and ENTRIES = 4:
  - Push 5 bytes: `FIFO_Full` = 1 and `FIFO_Overflow` = 1, with the 5th byte dropped.
  - Release `BIST_Mode`: the first 4 bytes are sent in order and `FIFO_Overflow` clears on the first pop.
- Simultaneous push and pop while full: FIFO full, STOP ending, push 0x5A on the pop edge. Count stays 4, no overflow, and 0x5A is transmitted last.
- Reset mid-frame: assert `rst` = 0 during DATA bit 3. After that edge, `Tx` = 1, `Tx_Busy` = 0, `FIFO_Empty` = 1; no `Tx_Done` pulse and no further frames.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit FIFO feeding a UART serialiser.
// Bytes pushed with Load_Data are queued and sent back-to-back on Tx.
// Each frame is start, data (LSB first), optional parity, then stop.
// Every output comes straight from a register.
module uart_tx_fifo #(
    parameter int DATA_BITS    = 8,
    parameter int FIFO_WIDTH   = 2,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] Tx_Data,
    input  logic                 Load_Data,
    input  logic                 BIST_Mode,
    output logic                 Tx,
    output logic                 Tx_Busy,
    output logic                 Tx_Done,
    output logic                 FIFO_Empty,
    output logic                 FIFO_Full,
    output logic                 FIFO_Overflow
);

    localparam int ENTRIES = 2 ** FIFO_WIDTH;
    localparam int CNT_W   = FIFO_WIDTH + 1;
    localparam int BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [BAUD_W-1:0]     BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0]     BAUD_ONE  = BAUD_W'(1);
    localparam logic [BIT_W-1:0]      BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]      BIT_ONE   = BIT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_FULL  = CNT_W'(ENTRIES);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [FIFO_WIDTH-1:0] PTR_ONE   = FIFO_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Parity bit for one frame: even = XOR of data, odd = its inverse.
    function automatic logic frame_parity(input logic [DATA_BITS-1:0] d);
        logic p;
        p = ^d;
        if (PARITY_ODD != 0) begin
            return ~p;
        end else begin
            return p;
        end
    endfunction

    logic [DATA_BITS-1:0]  mem_q [ENTRIES];
    logic [FIFO_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_q, baud_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d, busy_q, busy_d, done_q, done_d;

    logic                  pop_s, push_ok_s, can_start_s, baud_end_s;
    logic [DATA_BITS-1:0]  head_s;

    // Frame sequencer: decides pops and the next serial line level.
    always_comb begin
        state_d     = state_q;
        baud_d      = baud_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        par_d       = par_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pop_s       = 1'b0;
        head_s      = mem_q[rd_ptr_q];
        can_start_s = (count_q != {CNT_W{1'b0}}) && !BIST_Mode;
        baud_end_s  = (baud_q == BAUD_LAST);
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                baud_d = {BAUD_W{1'b0}};
                if (can_start_s) begin
                    pop_s   = 1'b1;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    shift_d = head_s;
                    par_d   = frame_parity(head_s);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_end_s) begin
                    baud_d  = {BAUD_W{1'b0}};
                    bit_d   = {BIT_W{1'b0}};
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_DATA: begin
                if (baud_end_s) begin
                    baud_d = {BAUD_W{1'b0}};
                    if (bit_q == BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d   = bit_q + BIT_ONE;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_PARITY: begin
                if (baud_end_s) begin
                    baud_d  = {BAUD_W{1'b0}};
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            S_STOP: begin
                if (baud_end_s) begin
                    baud_d = {BAUD_W{1'b0}};
                    done_d = 1'b1;
                    if (can_start_s) begin
                        // Chain straight into the next start bit, no idle gap.
                        pop_s   = 1'b1;
                        state_d = S_START;
                        tx_d    = 1'b0;
                        shift_d = head_s;
                        par_d   = frame_parity(head_s);
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                baud_d  = {BAUD_W{1'b0}};
            end
        endcase
    end

    // FIFO bookkeeping: a push into a full FIFO is accepted only when a pop frees a slot on the same edge.
    always_comb begin
        push_ok_s = Load_Data && ((count_q != CNT_FULL) || pop_s);
        wr_ptr_d  = push_ok_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d  = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_ok_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (Load_Data && !push_ok_s) begin
            ovf_d = 1'b1;
        end else if (pop_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        empty_d = (count_d == {CNT_W{1'b0}});
        full_d  = (count_d == CNT_FULL);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            baud_q   <= {BAUD_W{1'b0}};
            bit_q    <= {BIT_W{1'b0}};
            shift_q  <= {DATA_BITS{1'b0}};
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr_q <= {FIFO_WIDTH{1'b0}};
            rd_ptr_q <= {FIFO_WIDTH{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= Tx_Data;
        end
    end

    assign Tx            = tx_q;
    assign Tx_Busy       = busy_q;
    assign Tx_Done       = done_q;
    assign FIFO_Empty    = empty_q;
    assign FIFO_Full     = full_q;
    assign FIFO_Overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo at CLKS_PER_BIT = 4.
// dut_e uses even parity and carries most scenarios; dut_o uses odd parity.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] d_e, d_o;
    logic       ld_e, ld_o, bist_e, bist_o;
    logic       tx_e, busy_e, done_e, empty_e, full_e, ovf_e;
    logic       tx_o, busy_o, done_o, empty_o, full_o, ovf_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_WIDTH(2), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut_e (
        .clk(clk), .rst(rst), .Tx_Data(d_e), .Load_Data(ld_e), .BIST_Mode(bist_e),
        .Tx(tx_e), .Tx_Busy(busy_e), .Tx_Done(done_e),
        .FIFO_Empty(empty_e), .FIFO_Full(full_e), .FIFO_Overflow(ovf_e));

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_WIDTH(2), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut_o (
        .clk(clk), .rst(rst), .Tx_Data(d_o), .Load_Data(ld_o), .BIST_Mode(bist_o),
        .Tx(tx_o), .Tx_Busy(busy_o), .Tx_Done(done_o),
        .FIFO_Empty(empty_o), .FIFO_Full(full_o), .FIFO_Overflow(ovf_o));

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line levels of a frame, bit 0 = start bit, bit 10 = stop bit.
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic p);
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic test_reset();
        rst = 1'b0; ld_e = 1'b0; ld_o = 1'b0; bist_e = 1'b0; bist_o = 1'b0;
        d_e = 8'h00; d_o = 8'h00;
        tick(); tick();
        n_checks++; if (tx_e !== 1'b1)    begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx_e); end
        n_checks++; if (busy_e !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_e); end
        n_checks++; if (done_e !== 1'b0)  begin n_fail++; $display("FAIL reset_done: got %b want 0", done_e); end
        n_checks++; if (empty_e !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", empty_e); end
        n_checks++; if (full_e !== 1'b0)  begin n_fail++; $display("FAIL reset_full: got %b want 0", full_e); end
        n_checks++; if (ovf_e !== 1'b0)   begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf_e); end
        n_checks++; if (tx_o !== 1'b1)    begin n_fail++; $display("FAIL reset_tx_odd: got %b want 1", tx_o); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        logic [10:0] fb;
        fb = frame_bits(8'hA5, 1'b0);
        d_e = 8'hA5; ld_e = 1'b1;
        tick();
        ld_e = 1'b0;
        n_checks++; if (empty_e !== 1'b0) begin n_fail++; $display("FAIL single_empty_after_push: got %b want 0", empty_e); end
        n_checks++; if (tx_e !== 1'b1)    begin n_fail++; $display("FAIL single_tx_before_pop: got %b want 1", tx_e); end
        for (int i = 0; i < 44; i++) begin
            tick();
            n_checks++; if (tx_e !== fb[i/4]) begin n_fail++; $display("FAIL single_tx cyc %0d: got %b want %b", i, tx_e, fb[i/4]); end
            n_checks++; if (busy_e !== 1'b1)  begin n_fail++; $display("FAIL single_busy cyc %0d: got %b want 1", i, busy_e); end
            n_checks++; if (done_e !== 1'b0)  begin n_fail++; $display("FAIL single_done_early cyc %0d: got %b want 0", i, done_e); end
            if (i == 0) begin
                n_checks++; if (empty_e !== 1'b1) begin n_fail++; $display("FAIL single_empty_after_pop: got %b want 1", empty_e); end
            end
        end
        tick();
        n_checks++; if (done_e !== 1'b1) begin n_fail++; $display("FAIL single_done: got %b want 1", done_e); end
        n_checks++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL single_busy_end: got %b want 0", busy_e); end
        n_checks++; if (tx_e !== 1'b1)   begin n_fail++; $display("FAIL single_tx_idle: got %b want 1", tx_e); end
        tick();
        n_checks++; if (done_e !== 1'b0) begin n_fail++; $display("FAIL single_done_width: got %b want 0", done_e); end
    endtask

    task automatic test_parity();
        logic [10:0] fe, fo;
        fe = frame_bits(8'h07, 1'b1);
        fo = frame_bits(8'h07, 1'b0);
        d_e = 8'h07; d_o = 8'h07; ld_e = 1'b1; ld_o = 1'b1;
        tick();
        ld_e = 1'b0; ld_o = 1'b0;
        for (int i = 0; i < 44; i++) begin
            tick();
            n_checks++; if (tx_e !== fe[i/4]) begin n_fail++; $display("FAIL parity_even_tx cyc %0d: got %b want %b", i, tx_e, fe[i/4]); end
            n_checks++; if (tx_o !== fo[i/4]) begin n_fail++; $display("FAIL parity_odd_tx cyc %0d: got %b want %b", i, tx_o, fo[i/4]); end
        end
        tick();
        n_checks++; if (done_e !== 1'b1) begin n_fail++; $display("FAIL parity_even_done: got %b want 1", done_e); end
        n_checks++; if (done_o !== 1'b1) begin n_fail++; $display("FAIL parity_odd_done: got %b want 1", done_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [10:0] fr [3];
        fr[0] = frame_bits(8'h11, 1'b0);
        fr[1] = frame_bits(8'h22, 1'b0);
        fr[2] = frame_bits(8'h33, 1'b0);
        d_e = 8'h11; ld_e = 1'b1;
        tick();
        for (int i = 0; i < 132; i++) begin
            if (i == 0)      begin d_e = 8'h22; ld_e = 1'b1; end
            else if (i == 1) begin d_e = 8'h33; ld_e = 1'b1; end
            else             begin ld_e = 1'b0; end
            tick();
            n_checks++; if (tx_e !== fr[i/44][(i%44)/4]) begin n_fail++; $display("FAIL b2b_tx cyc %0d: got %b want %b", i, tx_e, fr[i/44][(i%44)/4]); end
            n_checks++; if (busy_e !== 1'b1) begin n_fail++; $display("FAIL b2b_busy cyc %0d: got %b want 1", i, busy_e); end
            n_checks++; if (done_e !== ((i == 44) || (i == 88))) begin n_fail++; $display("FAIL b2b_done cyc %0d: got %b want %b", i, done_e, ((i == 44) || (i == 88))); end
            n_checks++; if (empty_e !== (i >= 88)) begin n_fail++; $display("FAIL b2b_empty cyc %0d: got %b want %b", i, empty_e, (i >= 88)); end
        end
        tick();
        n_checks++; if (done_e !== 1'b1) begin n_fail++; $display("FAIL b2b_last_done: got %b want 1", done_e); end
        n_checks++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_busy: got %b want 0", busy_e); end
        tick();
    endtask

    task automatic test_overflow();
        logic [10:0] fr [4];
        fr[0] = frame_bits(8'hC1, 1'b1);
        fr[1] = frame_bits(8'hC2, 1'b1);
        fr[2] = frame_bits(8'hC3, 1'b0);
        fr[3] = frame_bits(8'hC4, 1'b1);
        bist_e = 1'b1;
        for (int k = 0; k < 5; k++) begin
            d_e = 8'hC1 + 8'(k); ld_e = 1'b1;
            tick();
            if (k == 3) begin
                n_checks++; if (full_e !== 1'b1) begin n_fail++; $display("FAIL ovf_full_at_4: got %b want 1", full_e); end
                n_checks++; if (ovf_e !== 1'b0)  begin n_fail++; $display("FAIL ovf_early: got %b want 0", ovf_e); end
            end
            if (k == 4) begin
                n_checks++; if (full_e !== 1'b1) begin n_fail++; $display("FAIL ovf_full_at_5: got %b want 1", full_e); end
                n_checks++; if (ovf_e !== 1'b1)  begin n_fail++; $display("FAIL ovf_set: got %b want 1", ovf_e); end
            end
        end
        ld_e = 1'b0;
        tick(); tick(); tick();
        n_checks++; if (tx_e !== 1'b1)   begin n_fail++; $display("FAIL ovf_bist_tx: got %b want 1", tx_e); end
        n_checks++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL ovf_bist_busy: got %b want 0", busy_e); end
        n_checks++; if (ovf_e !== 1'b1)  begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf_e); end
        bist_e = 1'b0;
        for (int i = 0; i < 176; i++) begin
            tick();
            n_checks++; if (tx_e !== fr[i/44][(i%44)/4]) begin n_fail++; $display("FAIL ovf_tx cyc %0d: got %b want %b", i, tx_e, fr[i/44][(i%44)/4]); end
            if (i == 0) begin
                n_checks++; if (ovf_e !== 1'b0)  begin n_fail++; $display("FAIL ovf_clear_on_pop: got %b want 0", ovf_e); end
                n_checks++; if (full_e !== 1'b0) begin n_fail++; $display("FAIL ovf_full_after_pop: got %b want 0", full_e); end
            end
        end
        tick();
        n_checks++; if (done_e !== 1'b1) begin n_fail++; $display("FAIL ovf_last_done: got %b want 1", done_e); end
        n_checks++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL ovf_no_fifth: got %b want 0", busy_e); end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++; if (tx_e !== 1'b1) begin n_fail++; $display("FAIL ovf_idle_tx cyc %0d: got %b want 1", i, tx_e); end
        end
    endtask

    task automatic test_push_pop_full();
        logic [10:0] fr [6];
        fr[0] = frame_bits(8'hD1, 1'b0);
        fr[1] = frame_bits(8'hD2, 1'b0);
        fr[2] = frame_bits(8'hD3, 1'b1);
        fr[3] = frame_bits(8'hD4, 1'b0);
        fr[4] = frame_bits(8'hD5, 1'b1);
        fr[5] = frame_bits(8'h5A, 1'b0);
        d_e = 8'hD1; ld_e = 1'b1;
        tick();
        for (int i = 0; i < 264; i++) begin
            if (i <= 3)       begin d_e = 8'hD2 + 8'(i); ld_e = 1'b1; end
            else if (i == 44) begin d_e = 8'h5A; ld_e = 1'b1; end
            else              begin ld_e = 1'b0; end
            tick();
            n_checks++; if (tx_e !== fr[i/44][(i%44)/4]) begin n_fail++; $display("FAIL pp_tx cyc %0d: got %b want %b", i, tx_e, fr[i/44][(i%44)/4]); end
            if ((i >= 3) && (i <= 44)) begin
                n_checks++; if (full_e !== 1'b1) begin n_fail++; $display("FAIL pp_full cyc %0d: got %b want 1", i, full_e); end
            end
            if (i == 44) begin
                n_checks++; if (ovf_e !== 1'b0)  begin n_fail++; $display("FAIL pp_no_ovf: got %b want 0", ovf_e); end
                n_checks++; if (done_e !== 1'b1) begin n_fail++; $display("FAIL pp_done: got %b want 1", done_e); end
            end
        end
        tick();
        n_checks++; if (busy_e !== 1'b0)  begin n_fail++; $display("FAIL pp_idle_busy: got %b want 0", busy_e); end
        n_checks++; if (empty_e !== 1'b1) begin n_fail++; $display("FAIL pp_idle_empty: got %b want 1", empty_e); end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        d_e = 8'h3C; ld_e = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            if (i == 0) begin d_e = 8'h99; ld_e = 1'b1; end
            else        begin ld_e = 1'b0; end
            tick();
        end
        n_checks++; if (busy_e !== 1'b1)  begin n_fail++; $display("FAIL rmf_busy_before: got %b want 1", busy_e); end
        n_checks++; if (empty_e !== 1'b0) begin n_fail++; $display("FAIL rmf_queued_before: got %b want 0", empty_e); end
        rst = 1'b0;
        tick();
        n_checks++; if (tx_e !== 1'b1)    begin n_fail++; $display("FAIL rmf_tx: got %b want 1", tx_e); end
        n_checks++; if (busy_e !== 1'b0)  begin n_fail++; $display("FAIL rmf_busy: got %b want 0", busy_e); end
        n_checks++; if (empty_e !== 1'b1) begin n_fail++; $display("FAIL rmf_empty: got %b want 1", empty_e); end
        rst = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            n_checks++; if (tx_e !== 1'b1)   begin n_fail++; $display("FAIL rmf_after_tx cyc %0d: got %b want 1", i, tx_e); end
            n_checks++; if (busy_e !== 1'b0) begin n_fail++; $display("FAIL rmf_after_busy cyc %0d: got %b want 0", i, busy_e); end
            n_checks++; if (done_e !== 1'b0) begin n_fail++; $display("FAIL rmf_after_done cyc %0d: got %b want 0", i, done_e); end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_parity();
        test_back_to_back();
        test_overflow();
        test_push_pop_full();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
